// File: rtl/fp_alu_arbiter_if.sv
// Request/response bus between the two requesters, the consumer and fp_alu_arbiter.
// Requester i occupies lane i of each packed request field.
interface fp_alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op_a;
    logic [63:0] req_op_b;
    logic [3:0]  req_op_code;
    logic [1:0]  req_mode_fp;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;

    modport master (
        output req_valid, req_op_a, req_op_b, req_op_code, req_mode_fp,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b, req_op_code, req_mode_fp,
        output req_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  rsp_ready
    );
endinterface

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter sharing one combinational FP ALU between two requesters,
// holding operands for ALU_LAT cycles and keeping per-requester sticky flags.
module fp_alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_alu_arbiter_if.slave       bus,
    output logic [31:0]           alu_op_a,
    output logic [31:0]           alu_op_b,
    output logic [1:0]            alu_op_code,
    output logic                  alu_mode_fp,
    output logic                  alu_start,
    input  logic [31:0]           alu_result,
    input  logic [4:0]            alu_flags,
    output logic [9:0]            sticky_flags,
    input  logic [1:0]            sticky_clr,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        sel;
    logic        accept;
    logic        cap;
    logic        rsp_hs;
    logic [3:0]  cnt;
    logic [9:0]  sticky_nxt;

    // On a tie the requester not served last wins
    always_comb begin
        sel = 1'b0;
        unique case (bus.req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_grant;
            default: sel = 1'b0;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (rst && state == IDLE)
            bus.req_ready[sel] = bus.req_valid[sel];
    end

    assign accept = |(bus.req_valid & bus.req_ready);
    assign cap    = (state == EXEC) && (cnt == 4'd1);
    assign rsp_hs = (state == RESP) && bus.rsp_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cap) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A clear and a same-cycle set resolve to the new flags only
    always_comb begin
        sticky_nxt = sticky_flags;
        for (int i = 0; i < 2; i++) begin
            if (sticky_clr[i])
                sticky_nxt[5*i +: 5] = 5'b0;
            if (rsp_hs && bus.rsp_id == i[0])
                sticky_nxt[5*i +: 5] = sticky_nxt[5*i +: 5] | bus.rsp_flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant     <= 1'b1;
            cnt            <= 4'd0;
            alu_op_a       <= 32'd0;
            alu_op_b       <= 32'd0;
            alu_op_code    <= 2'd0;
            alu_mode_fp    <= 1'b0;
            alu_start      <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= 32'd0;
            bus.rsp_flags  <= 5'd0;
            sticky_flags   <= 10'd0;
        end else begin
            alu_start    <= accept;
            sticky_flags <= sticky_nxt;
            if (accept) begin
                last_grant  <= sel;
                cnt         <= ALU_LAT[3:0];
                alu_op_a    <= bus.req_op_a[{sel, 5'd0} +: 32];
                alu_op_b    <= bus.req_op_b[{sel, 5'd0} +: 32];
                alu_op_code <= bus.req_op_code[{sel, 1'b0} +: 2];
                alu_mode_fp <= bus.req_mode_fp[sel];
                bus.rsp_id  <= sel;
            end
            if (state == EXEC)
                cnt <= cnt - 4'd1;
            if (cap) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_result <= alu_result;
                bus.rsp_flags  <= alu_flags;
            end else if (rsp_hs) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed bench for fp_alu_arbiter: two instances (ALU_LAT 1 and 4) share a
// clock and reset; a stub ALU answers the vectors used below.
module tb_fp_alu_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a [2];
    logic [31:0] alu_b [2];
    logic [1:0]  alu_c [2];
    logic        alu_m [2];
    logic        alu_s [2];
    logic [31:0] alu_r [2];
    logic [4:0]  alu_f [2];
    logic [9:0]  stk   [2];
    logic [1:0]  sclr  [2];
    logic        bsy   [2];

    int   errs;
    int   checks;
    exp_t q[$];

    fp_alu_arbiter_if b0();
    fp_alu_arbiter_if b1();

    fp_alu_arbiter #(.ALU_LAT(1)) u0 (
        .clk(clk), .rst(rst), .bus(b0),
        .alu_op_a(alu_a[0]), .alu_op_b(alu_b[0]),
        .alu_op_code(alu_c[0]), .alu_mode_fp(alu_m[0]),
        .alu_start(alu_s[0]), .alu_result(alu_r[0]),
        .alu_flags(alu_f[0]), .sticky_flags(stk[0]),
        .sticky_clr(sclr[0]), .busy(bsy[0])
    );

    fp_alu_arbiter #(.ALU_LAT(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1),
        .alu_op_a(alu_a[1]), .alu_op_b(alu_b[1]),
        .alu_op_code(alu_c[1]), .alu_mode_fp(alu_m[1]),
        .alu_start(alu_s[1]), .alu_result(alu_r[1]),
        .alu_flags(alu_f[1]), .sticky_flags(stk[1]),
        .sticky_clr(sclr[1]), .busy(bsy[1])
    );

    // Stub ALU: {flags, result} for the operand patterns this bench drives
    function automatic logic [36:0] model(logic [31:0] a, logic [31:0] b,
                                          logic [1:0] c, logic m);
        if (c == 2'd2 && a == 32'h3F800000 && b == 32'h40000000)
            return {5'b00000, 32'h40000000};
        if (c == 2'd0 && m && a[15:0] == 16'h3C00 && b[15:0] == 16'h3C00)
            return {5'b00000, 32'h00004000};
        if (c == 2'd3 && b == 32'd0)
            return {5'b01000, 32'h7F800000};
        if (c == 2'd1 && a == 32'h7F800000 && b == 32'h7F800000)
            return {5'b10000, 32'h7FC00000};
        return 37'd0;
    endfunction

    always_comb {alu_f[0], alu_r[0]} = model(alu_a[0], alu_b[0], alu_c[0], alu_m[0]);
    always_comb {alu_f[1], alu_r[1]} = model(alu_a[1], alu_b[1], alu_c[1], alu_m[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic rv(int d);
        return (d == 0) ? b0.rsp_valid : b1.rsp_valid;
    endfunction

    function automatic logic rid(int d);
        return (d == 0) ? b0.rsp_id : b1.rsp_id;
    endfunction

    function automatic logic [31:0] rres(int d);
        return (d == 0) ? b0.rsp_result : b1.rsp_result;
    endfunction

    function automatic logic [4:0] rflg(int d);
        return (d == 0) ? b0.rsp_flags : b1.rsp_flags;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int d, int id, logic [31:0] a, logic [31:0] b,
                         logic [1:0] c, logic m);
        if (d == 0) begin
            b0.req_op_a[32*id +: 32]  = a;
            b0.req_op_b[32*id +: 32]  = b;
            b0.req_op_code[2*id +: 2] = c;
            b0.req_mode_fp[id]        = m;
            b0.req_valid[id]          = 1'b1;
        end else begin
            b1.req_op_a[32*id +: 32]  = a;
            b1.req_op_b[32*id +: 32]  = b;
            b1.req_op_code[2*id +: 2] = c;
            b1.req_mode_fp[id]        = m;
            b1.req_valid[id]          = 1'b1;
        end
    endtask

    // Entered on the negedge just after the accepting edge; counts negedges
    // until rsp_valid, checking operands hold and start stays low meanwhile.
    task automatic run_rsp(int d, int lat);
        int          k;
        logic [31:0] a0;
        exp_t        e;
        k  = 0;
        a0 = alu_a[d];
        while (!rv(d) && k < 40) begin
            @(negedge clk);
            k++;
            if (!rv(d)) begin
                chk("start_low", {31'd0, alu_s[d]}, 32'd0);
                chk("opa_hold", alu_a[d], a0);
            end
        end
        chk("latency", k, lat);
        chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_id", {31'd0, rid(d)}, {31'd0, e.id});
            chk("rsp_result", rres(d), e.res);
            chk("rsp_flags", {27'd0, rflg(d)}, {27'd0, e.flg});
        end
    endtask

    initial begin
        logic seen;
        errs   = 0;
        checks = 0;
        rst    = 1'b0;
        b0.req_valid = 2'b11;  b1.req_valid = 2'b00;
        b0.req_op_a = '0;      b1.req_op_a = '0;
        b0.req_op_b = '0;      b1.req_op_b = '0;
        b0.req_op_code = '0;   b1.req_op_code = '0;
        b0.req_mode_fp = '0;   b1.req_mode_fp = '0;
        b0.rsp_ready = 1'b0;   b1.rsp_ready = 1'b0;
        sclr[0] = 2'b00;       sclr[1] = 2'b00;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {30'd0, b0.req_ready}, 32'd0);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("rst_rsp_valid", {31'd0, b0.rsp_valid}, 32'd0);
        chk("rst_sticky", {22'd0, stk[0]}, 32'd0);
        chk("rst_alu_a", alu_a[0], 32'd0);
        chk("rst_alu_start", {31'd0, alu_s[0]}, 32'd0);
        chk("rst_rsp_result", b0.rsp_result, 32'd0);
        chk("rst_rsp_id", {31'd0, b0.rsp_id}, 32'd0);
        b0.req_valid = 2'b00;
        rst = 1'b1;

        // Tie right after reset: requester 0 first, then 1
        @(negedge clk);
        drive(0, 0, 32'h3C00, 32'h3C00, 2'd0, 1'b1);
        drive(0, 1, 32'h3C00, 32'h3C00, 2'd0, 1'b1);
        #1 chk("tie_ready", {30'd0, b0.req_ready}, 32'd1);
        q.push_back('{id: 1'b0, res: 32'h4000, flg: 5'b0});
        q.push_back('{id: 1'b1, res: 32'h4000, flg: 5'b0});
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.req_valid = 2'b10;
        chk("tie_busy", {31'd0, bsy[0]}, 32'd1);
        chk("tie_start", {31'd0, alu_s[0]}, 32'd1);
        chk("tie_mode", {31'd0, alu_m[0]}, 32'd1);
        run_rsp(0, 1);
        @(negedge clk);
        chk("tie_ready_r1", {30'd0, b0.req_ready}, 32'd2);
        chk("tie_rsp_clear", {31'd0, b0.rsp_valid}, 32'd0);
        @(negedge clk);
        b0.req_valid = 2'b00;
        run_rsp(0, 1);

        // Single mul from requester 0
        @(negedge clk);
        drive(0, 0, 32'h3F800000, 32'h40000000, 2'd2, 1'b0);
        #1 chk("mul_ready", {30'd0, b0.req_ready}, 32'd1);
        q.push_back('{id: 1'b0, res: 32'h40000000, flg: 5'b0});
        @(negedge clk);
        b0.req_valid = 2'b00;
        chk("mul_alu_a", alu_a[0], 32'h3F800000);
        chk("mul_alu_b", alu_b[0], 32'h40000000);
        chk("mul_alu_code", {30'd0, alu_c[0]}, 32'd2);
        chk("mul_start", {31'd0, alu_s[0]}, 32'd1);
        run_rsp(0, 1);

        // Divide by zero on requester 1, sticky set then cleared
        @(negedge clk);
        drive(0, 1, 32'h3F800000, 32'h0, 2'd3, 1'b0);
        q.push_back('{id: 1'b1, res: 32'h7F800000, flg: 5'b01000});
        @(negedge clk);
        b0.req_valid = 2'b00;
        run_rsp(0, 1);
        @(negedge clk);
        chk("div_sticky", {22'd0, stk[0]}, 32'h100);
        sclr[0] = 2'b10;
        @(negedge clk);
        sclr[0] = 2'b00;
        chk("sticky_clr", {22'd0, stk[0]}, 32'd0);

        // Clear coinciding with a new set keeps the new flags
        drive(0, 1, 32'h3F800000, 32'h0, 2'd3, 1'b0);
        q.push_back('{id: 1'b1, res: 32'h7F800000, flg: 5'b01000});
        @(negedge clk);
        b0.req_valid = 2'b00;
        run_rsp(0, 1);
        sclr[0] = 2'b10;
        @(negedge clk);
        sclr[0] = 2'b00;
        chk("clr_and_set", {22'd0, stk[0]}, 32'h100);

        // Backpressure: hold rsp_ready low for 5 cycles
        b0.rsp_ready = 1'b0;
        drive(0, 0, 32'h3F800000, 32'h40000000, 2'd2, 1'b0);
        q.push_back('{id: 1'b0, res: 32'h40000000, flg: 5'b0});
        @(negedge clk);
        b0.req_valid = 2'b11;
        run_rsp(0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, b0.rsp_valid}, 32'd1);
            chk("bp_result", b0.rsp_result, 32'h40000000);
            chk("bp_flags", {27'd0, b0.rsp_flags}, 32'd0);
            chk("bp_req_ready", {30'd0, b0.req_ready}, 32'd0);
            chk("bp_busy", {31'd0, bsy[0]}, 32'd1);
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, b0.rsp_valid}, 32'd0);
        chk("bp_release_busy", {31'd0, bsy[0]}, 32'd0);
        b0.req_valid = 2'b00;
        @(negedge clk);
        chk("drop_no_accept", {31'd0, bsy[0]}, 32'd0);

        // ALU_LAT=4: inf - inf
        drive(1, 0, 32'h7F800000, 32'h7F800000, 2'd1, 1'b0);
        q.push_back('{id: 1'b0, res: 32'h7FC00000, flg: 5'b10000});
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.req_valid = 2'b00;
        chk("lat4_start", {31'd0, alu_s[1]}, 32'd1);
        chk("lat4_alu_a", alu_a[1], 32'h7F800000);
        run_rsp(1, 4);
        @(negedge clk);
        chk("lat4_sticky", {22'd0, stk[1]}, 32'h010);
        chk("lat4_idle", {31'd0, bsy[1]}, 32'd0);

        // Reset during the second EXEC cycle discards the operation
        drive(1, 1, 32'h3F800000, 32'h40000000, 2'd2, 1'b0);
        @(negedge clk);
        b1.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bsy[1]}, 32'd0);
        chk("mid_rst_alu_a", alu_a[1], 32'd0);
        chk("mid_rst_start", {31'd0, alu_s[1]}, 32'd0);
        chk("mid_rst_valid", {31'd0, b1.rsp_valid}, 32'd0);
        chk("mid_rst_sticky", {22'd0, stk[1]}, 32'd0);
        chk("mid_rst_result", b1.rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | b1.rsp_valid;
        end
        chk("post_rst_no_rsp", {31'd0, seen}, 32'd0);
        chk("sb_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
